tl_instruction_fetch: RTL and testbench

Instruction fetch stage of the pipelined MIPS core, sitting directly upstream of `tl_instruction_decode`. Holds the program counter, reads a word-addressed instruction memory loaded by the debug/loader unit, and drives the IF/ID pipeline register consumed by decode. Supports hazard-unit stall, branch/jump redirect with flush, and a global run enable for step mode.

---
 rtl/mips_pkg.sv | 13 +
 rtl/instruction_memory.sv | 37 +++
 rtl/tl_instruction_fetch.sv | 105 ++++++++++
 tb/tb_tl_instruction_fetch.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : constants shared by the MIPS pipeline stages
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;
    localparam logic [5:0]  OPCODE_HALT = 6'b111111;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;
    localparam int unsigned PC_INCR     = 4;
endpackage

`default_nettype wire

// File: rtl/instruction_memory.sv
// ============================================================================
// instruction_memory : word-addressed RAM, one sync write port, one sync
//                      read port with enable, read-first on address collision
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module instruction_memory #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [NB_ADDR-1:0] wr_addr,
    input  logic [NB_DATA-1:0] wr_data,
    input  logic               rd_en,
    input  logic [NB_ADDR-1:0] rd_addr,
    output logic [NB_DATA-1:0] rd_data
);

    localparam int DEPTH = 1 << NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    // Read and write share one process so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/tl_instruction_fetch.sv
// ============================================================================
// tl_instruction_fetch : IF stage - PC, instruction memory and IF/ID register
// Optional macro IF_HALT_DETECT_EN : freeze the stage after fetching HALT
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tl_instruction_fetch
    import mips_pkg::*;
#(
    parameter int len         = 32,
    parameter int NB_ADDR_MEM = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_pc_src,
    input  logic [len-1:0]         i_pc_target,
    input  logic                   i_wr_en,
    input  logic [NB_ADDR_MEM-1:0] i_wr_addr,
    input  logic [len-1:0]         i_wr_data,
    output logic [len-1:0]         o_instruccion,
    output logic [len-1:0]         o_pc_mas_4,
    output logic                   o_valid,
    output logic [len-1:0]         o_pc,
    output logic                   o_halt
);

    logic [len-1:0] pc;
    logic [len-1:0] pc_plus_4;
    logic [len-1:0] pc_next;
    logic [len-1:0] ifid_pc_mas_4;
    logic [len-1:0] mem_rd_data;
    logic           ifid_valid;
    logic           halted;
    logic           advance;
    logic           redirect;

    assign pc_plus_4 = pc + len'(PC_INCR);
    assign pc_next   = i_pc_src ? (i_pc_target & ~len'(3)) : pc_plus_4;

`ifdef IF_HALT_DETECT_EN
    logic halt_seen;
    logic halt_q;

    // The memory output register is the IF/ID instruction, so a captured HALT
    // is visible right after its fetch edge; halt_q keeps it sticky.
    assign halt_seen = ifid_valid & (mem_rd_data[len-1 -: 6] == OPCODE_HALT);
    assign halted    = halt_q | halt_seen;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            halt_q <= 1'b0;
        end else if (halt_seen) begin
            halt_q <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    assign advance  = i_enable & ~i_stall & ~halted;
    assign redirect = i_enable & i_flush & ~halted;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc            <= '0;
            ifid_valid    <= 1'b0;
            ifid_pc_mas_4 <= '0;
        end else if (redirect) begin
            pc            <= pc_next;
            ifid_valid    <= 1'b0;
            ifid_pc_mas_4 <= '0;
        end else if (advance) begin
            pc            <= pc_next;
            ifid_valid    <= 1'b1;
            ifid_pc_mas_4 <= pc_plus_4;
        end
    end

    instruction_memory #(
        .NB_DATA (len),
        .NB_ADDR (NB_ADDR_MEM)
    ) u_imem (
        .clk     (i_clk),
        .wr_en   (i_wr_en),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (advance & ~redirect),
        .rd_addr (pc[NB_ADDR_MEM+1:2]),
        .rd_data (mem_rd_data)
    );

    // A bubble must look like a NOP to decode regardless of the RAM register.
    assign o_instruccion = ifid_valid ? mem_rd_data : len'(INSTR_NOP);
    assign o_pc_mas_4    = ifid_pc_mas_4;
    assign o_valid       = ifid_valid;
    assign o_pc          = pc;
    assign o_halt        = halted;

endmodule

`default_nettype wire

// File: tb/tb_tl_instruction_fetch.sv
// ============================================================================
// tb_tl_instruction_fetch : directed self-checking bench for the IF stage
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tb_tl_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        stall;
    logic        flush;
    logic        pc_src;
    logic [31:0] pc_target;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] instruccion;
    logic [31:0] pc_mas_4;
    logic        valid;
    logic [31:0] pc;
    logic        halt;

    int passed = 0;
    int total  = 0;

    tl_instruction_fetch #(
        .len         (32),
        .NB_ADDR_MEM (10)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_pc_src      (pc_src),
        .i_pc_target   (pc_target),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_instruccion (instruccion),
        .o_pc_mas_4    (pc_mas_4),
        .o_valid       (valid),
        .o_pc          (pc),
        .o_halt        (halt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid,
                            input logic [31:0] e_pc);
        chk({tag, ".instr"}, instruccion, e_instr);
        chk({tag, ".pc4"},   pc_mas_4,    e_pc4);
        chk({tag, ".valid"}, {31'b0, valid}, {31'b0, e_valid});
        chk({tag, ".pc"},    pc,          e_pc);
    endtask

    task automatic load(input logic [9:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        flush     = 1'b1;
        pc_src    = 1'b1;
        pc_target = tgt;
        tick();
        flush     = 1'b0;
        pc_src    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
        pc_target = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(); tick();
        chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("reset.halt", {31'b0, halt}, 32'h0);

        rst = 1'b0;
        load(10'd0,     32'h0000_0011);
        load(10'd1,     32'h0000_0022);
        load(10'd2,     32'h0000_0033);
        load(10'd3,     32'hFC00_0000);
        load(10'd4,     32'h0000_0055);
        load(10'h010,   32'h0000_00AA);
        load(10'h011,   32'h0000_00BB);
        load(10'h3FF,   32'h0000_0077);
        chk_ifid("disabled_load", 32'h0, 32'h0, 1'b0, 32'h0);

        // Sequential fetch
        enable = 1'b1;
        tick(); chk_ifid("fetch0", 32'h11, 32'd4, 1'b1, 32'd4);
        tick(); chk_ifid("fetch1", 32'h22, 32'd8, 1'b1, 32'd8);

        // Three stalled cycles hold 0x22, then 0x33 follows
        stall = 1'b1;
        tick(); chk_ifid("stall1", 32'h22, 32'd8, 1'b1, 32'd8);
        tick(); chk_ifid("stall2", 32'h22, 32'd8, 1'b1, 32'd8);
        tick(); chk_ifid("stall3", 32'h22, 32'd8, 1'b1, 32'd8);
        stall = 1'b0;
        tick(); chk_ifid("resume", 32'h33, 32'd12, 1'b1, 32'd12);

        // Flush to an unaligned target; low bits are dropped
        redirect_to(32'h0000_0043);
        chk_ifid("flush_bubble", 32'h0, 32'h0, 1'b0, 32'h40);
        tick(); chk_ifid("flush_target", 32'hAA, 32'h44, 1'b1, 32'h44);

        // Flush beats a simultaneous stall
        stall = 1'b1;
        redirect_to(32'h0000_0040);
        stall = 1'b0;
        chk_ifid("flush_stall", 32'h0, 32'h0, 1'b0, 32'h40);
        tick(); chk_ifid("after_fs", 32'hAA, 32'h44, 1'b1, 32'h44);

        // Flush while disabled is ignored
        enable = 1'b0;
        redirect_to(32'h0);
        chk_ifid("flush_disabled", 32'hAA, 32'h44, 1'b1, 32'h44);
        enable = 1'b1;
        tick(); chk_ifid("reenable", 32'hBB, 32'h48, 1'b1, 32'h48);

        // Run up to the HALT word at address 3
        redirect_to(32'h8);
        chk_ifid("to_halt_bubble", 32'h0, 32'h0, 1'b0, 32'h8);
        tick(); chk_ifid("pre_halt", 32'h33, 32'd12, 1'b1, 32'd12);
        tick(); chk_ifid("halt_fetch", 32'hFC00_0000, 32'd16, 1'b1, 32'd16);
`ifdef IF_HALT_DETECT_EN
        chk("halt_set", {31'b0, halt}, 32'h1);
        tick(); chk_ifid("halt_frozen", 32'hFC00_0000, 32'd16, 1'b1, 32'd16);
        redirect_to(32'h0);
        chk_ifid("halt_no_redirect", 32'hFC00_0000, 32'd16, 1'b1, 32'd16);
        chk("halt_sticky", {31'b0, halt}, 32'h1);
`else
        chk("halt_off", {31'b0, halt}, 32'h0);
        tick(); chk_ifid("past_halt", 32'h55, 32'd20, 1'b1, 32'd20);
`endif

        // Reset mid-run clears IF/ID, PC and halt
        rst = 1'b1; enable = 1'b0;
        tick();
        rst = 1'b0;
        chk_ifid("rst_mid", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rst_mid.halt", {31'b0, halt}, 32'h0);

        // Loader write collides with fetch of the same word: old data wins
        enable  = 1'b1;
        wr_en   = 1'b1; wr_addr = 10'd0; wr_data = 32'h0000_0099;
        tick();
        wr_en   = 1'b0;
        chk_ifid("rd_first_old", 32'h11, 32'd4, 1'b1, 32'd4);
        redirect_to(32'h0);
        chk_ifid("rd_first_bubble", 32'h0, 32'h0, 1'b0, 32'h0);
        tick(); chk_ifid("rd_first_new", 32'h99, 32'd4, 1'b1, 32'd4);

        // PC+4 wraps and the top memory word aliases from a high PC
        redirect_to(32'hFFFF_FFFC);
        chk_ifid("wrap_bubble", 32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC);
        tick(); chk_ifid("wrap", 32'h77, 32'h0, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
